// File: rtl/fetch_unit.sv
// Fetch stage: PC, in-order word reads (credit limited), {pc, insn} buffer toward decode.
// Latency: a word returned at cycle t is presented at t+1; stall holds the head, full buffer throttles mem_req.
module fetch_unit #(
  parameter logic [0:31] START_PC        = 32'h80020000,
  parameter int          MAX_OUTSTANDING = 2,
  parameter int          BUF_DEPTH       = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [0:31] redirect_pc,
  output logic        mem_req,
  output logic [0:31] mem_addr,
  input  logic        mem_rvalid,
  input  logic [0:31] mem_rdata,
  output logic [0:31] insn,
  output logic [0:31] pc,
  output logic        valid_insn
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int OW = $clog2(BUF_DEPTH + 1);
  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int AW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  localparam logic [CW-1:0] MAX_O   = CW'(MAX_OUTSTANDING);
  localparam logic [OW:0]   DEPTH_V = (OW + 1)'(BUF_DEPTH);

  typedef struct packed {
    logic [0:31] pc;
    logic [0:31] insn;
  } entry_t;

  logic [0:31]   fetch_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] outstanding_nxt;
  logic [CW-1:0] drop_cnt;
  logic [OW-1:0] occ;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  entry_t        buf_mem [BUF_DEPTH];
  logic [0:31]   addr_q  [MAX_OUTSTANDING];
  logic [0:31]   addr_q_nxt [MAX_OUTSTANDING];
  logic [AW-1:0] aq_wr;
  logic [OW:0]   credit_used;

  logic issue;
  logic resp;
  logic drop;
  logic push;
  logic pop;
  logic unused_lsb;

  assign unused_lsb = ^redirect_pc[30:31];

  // Reads in flight plus buffered words never exceed the buffer, so pushes always fit.
  assign credit_used = (OW + 1)'(outstanding) + (OW + 1)'(occ);
  assign issue = rst_n & ~redirect & (outstanding < MAX_O) & (credit_used < DEPTH_V);

  // A response only counts against a read we issued; anything else is a stray.
  assign resp = rst_n & mem_rvalid & (outstanding != '0);
  assign drop = resp & (drop_cnt != '0);
  assign push = resp & (drop_cnt == '0) & ~redirect;

  assign valid_insn = rst_n & (occ != '0) & ~redirect;
  assign pop        = valid_insn & ~stall;

  assign mem_req  = issue;
  assign mem_addr = fetch_pc;
  assign insn     = rst_n ? buf_mem[rd_ptr].insn : '0;
  assign pc       = rst_n ? buf_mem[rd_ptr].pc   : '0;

  always_comb begin
    outstanding_nxt = outstanding;
    if (issue && !resp) begin
      outstanding_nxt = outstanding + CW'(1);
    end else if (!issue && resp) begin
      outstanding_nxt = outstanding - CW'(1);
    end
  end

  // Request addresses kept oldest-first; a counted response shifts the queue down.
  assign aq_wr = AW'(outstanding - CW'(resp));

  always_comb begin
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      addr_q_nxt[i] = addr_q[i];
    end
    if (resp) begin
      for (int i = 0; i < MAX_OUTSTANDING - 1; i++) begin
        addr_q_nxt[i] = addr_q[i + 1];
      end
    end
    if (issue) begin
      addr_q_nxt[aq_wr] = fetch_pc;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      addr_q[i] <= addr_q_nxt[i];
    end
    if (push) begin
      buf_mem[wr_ptr] <= '{pc: addr_q[0], insn: mem_rdata};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc    <= START_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      occ         <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else begin
      outstanding <= outstanding_nxt;

      if (redirect) begin
        fetch_pc <= {redirect_pc[0:29], 2'b00};
      end else if (issue) begin
        fetch_pc <= fetch_pc + 32'd4;
      end

      // Every read still in flight after this edge predates the redirect.
      if (redirect) begin
        drop_cnt <= outstanding_nxt;
      end else if (drop) begin
        drop_cnt <= drop_cnt - CW'(1);
      end

      if (redirect) begin
        occ    <= '0;
        wr_ptr <= rd_ptr;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + PW'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PW'(1);
        end
        if (push && !pop) begin
          occ <= occ + OW'(1);
        end else if (!push && pop) begin
          occ <= occ - OW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit against an in-order memory and a stream-level reference model.
module tb_fetch_unit;

  localparam int          MAXO  = 2;
  localparam int          DEPTH = 4;
  localparam logic [31:0] START = 32'h80020000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [31:0] insn;
  logic [31:0] pc;
  logic        valid_insn;

  fetch_unit #(
    .START_PC       (START),
    .MAX_OUTSTANDING(MAXO),
    .BUF_DEPTH      (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .insn       (insn),
    .pc         (pc),
    .valid_insn (valid_insn)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
    int          epoch;
    int          gen;
  } req_t;

  req_t        mq[$];
  int          cyc = 0;
  int          epoch = 0;
  int          gen = 0;
  int          occ = 0;
  int          last_due = 0;
  int          lat_fixed = 1;
  logic [31:0] exp_pc = START;
  logic [31:0] exp_addr = START;
  logic        s_valid;
  int          n_chk = 0;
  int          n_pass = 0;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return a ^ 32'h13579BDF;
  endfunction

  function automatic int outs_now();
    int n = 0;
    foreach (mq[k]) if (mq[k].epoch == epoch) n++;
    return n;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      $display("FAIL %s: got %h expected %h at cycle %0d", tag, got, exp, cyc);
    end else begin
      n_pass++;
    end
  endtask

  // One clock cycle: drive memory and control, check outputs, then advance the model.
  task automatic step(input bit rst, input bit st, input bit rd, input logic [31:0] tgt);
    req_t r;
    bit   has_resp = 0;
    bit   exp_req;
    bit   exp_vld;
    int   outs;
    int   lat;
    outs = outs_now();
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      r = mq.pop_front();
      has_resp = 1;
    end
    mem_rvalid  = has_resp;
    mem_rdata   = has_resp ? mem_fn(r.addr) : $urandom;
    rst_n       = rst;
    stall       = st;
    redirect    = rd;
    redirect_pc = tgt;
    #1;
    exp_req = rst && !rd && (outs < MAXO) && (outs + occ < DEPTH);
    exp_vld = rst && (occ > 0) && !rd;
    if (!rst) begin
      check("rst_mem_req", mem_req, 0);
      check("rst_valid", valid_insn, 0);
      check("rst_insn", insn, 0);
      check("rst_pc", pc, 0);
    end else begin
      check("mem_req", mem_req, exp_req);
      if (exp_req) check("mem_addr", mem_addr, exp_addr);
      check("valid_insn", valid_insn, exp_vld);
      if (exp_vld) begin
        check("pc", pc, exp_pc);
        check("insn", insn, mem_fn(exp_pc));
      end
    end
    s_valid = valid_insn;

    if (!rst) begin
      epoch++;
      occ      = 0;
      exp_pc   = START;
      exp_addr = START;
    end else begin
      if (exp_vld && !st) begin
        occ--;
        exp_pc += 32'd4;
      end
      if (has_resp && r.epoch == epoch && r.gen == gen && !rd) occ++;
      if (exp_req) begin
        lat = (lat_fixed > 0) ? lat_fixed : int'($urandom_range(1, 4));
        last_due = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
        mq.push_back('{addr: exp_addr, due: last_due, epoch: epoch, gen: gen});
        exp_addr += 32'd4;
      end
      if (rd) begin
        occ = 0;
        gen++;
        exp_pc   = {tgt[31:2], 2'b00};
        exp_addr = {tgt[31:2], 2'b00};
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n, input bit st);
    for (int i = 0; i < n; i++) step(1, st, 0, 32'h0);
  endtask

  task automatic wait_outs2(input string tag);
    int i = 0;
    while (i < 20 && outs_now() != 2) begin
      step(1, 0, 0, 32'h0);
      i++;
    end
    check(tag, outs_now(), 2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_chk);
    $fatal(1);
  end

  initial begin
    int first;
    bit found;
    rst_n = 0; stall = 0; redirect = 0; redirect_pc = '0;
    mem_rvalid = 0; mem_rdata = '0;
    @(posedge clk);
    #1;

    // Reset, then streaming at latency 1.
    lat_fixed = 1;
    step(0, 0, 0, 32'h0);
    step(0, 0, 0, 32'h0);
    first = -1;
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 0, 32'h0);
      if (s_valid && first < 0) first = i;
    end
    check("first_valid_cycle", first, 2);
    run(10, 0);

    // Long stall fills the buffer and throttles requests.
    run(10, 1);
    run(12, 0);

    // Redirect with two reads in flight at latency 2.
    lat_fixed = 2;
    wait_outs2("wait_out2_redirect");
    step(1, 0, 1, 32'h00400013);
    run(15, 0);

    // Address wrap.
    lat_fixed = 1;
    step(1, 0, 1, 32'hFFFFFFF8);
    run(12, 0);

    // Reset mid-stream; one response arrives after release with nothing outstanding.
    lat_fixed = 2;
    wait_outs2("wait_out2_reset");
    step(0, 0, 0, 32'h0);
    run(14, 0);

    // Back-to-back redirects, second one coincides with a returning word.
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (mq.size() == 2 && mq[1].due == cyc + 1 && outs_now() == 2) found = 1;
      else step(1, 0, 0, 32'h0);
    end
    check("wait_b2b", found, 1);
    step(1, 0, 1, 32'h00000100);
    step(1, 0, 1, 32'h00000200);
    run(14, 0);

    // Random traffic: variable latency, stalls, redirects, occasional reset.
    lat_fixed = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        for (int k = 0; k < 12 && (k == 0 || mq.size() > 0); k++) step(0, 0, 0, 32'h0);
      end else begin
        step(1, $urandom_range(0, 9) < 3, $urandom_range(0, 99) < 4, $urandom);
      end
    end
    run(20, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
